// File: rtl/btn_debounce_bank_if.sv
// Button bank signal bundle: raw buttons in, debounced level/pulse out, FSM state for observation.
// No valid/ready handshake here: db_level is a plain level and db_tick a one-clk strobe with no backpressure.
interface btn_debounce_bank_if #(
  parameter int N = 4
);
  logic [N-1:0]   btn_raw;
  logic [N-1:0]   db_level;
  logic [N-1:0]   db_tick;
  logic [2*N-1:0] dbg_state;

  modport master (output btn_raw, input db_level, input db_tick, input dbg_state);
  modport slave  (input btn_raw, output db_level, output db_tick, output dbg_state);
endinterface

// File: rtl/btn_debounce_bank.sv
// N-channel push-button conditioner: 2-flop synchroniser, shared sample-tick prescaler,
// per-channel debounce FSM producing a clean level and a single-cycle press pulse.
module btn_debounce_bank #(
  parameter int N        = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter int SAMPLES  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_debounce_bank_if.slave   bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (SAMPLES > 0) ? $clog2(SAMPLES + 1) : 1;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          m_tick;

  state_e        state_q [N];
  state_e        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  tick_q, tick_d;

  assign m_tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    sync1_d = bus.btn_raw;
    sync2_d = sync1_q;
    presc_d = m_tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    level_d = '0;
    tick_d  = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ZERO: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          if (!sync2_q[i]) begin
            state_d[i] = ZERO;
          end else if (m_tick) begin
            if (cnt_q[i] == CW'(SAMPLES - 1)) state_d[i] = ONE;
            else                              cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        ONE: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (sync2_q[i]) begin
            state_d[i] = ONE;
          end else if (m_tick) begin
            if (cnt_q[i] == CW'(SAMPLES - 1)) state_d[i] = ZERO;
            else                              cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = ZERO;
      endcase
      // Outputs are registered from the next state so level and pulse land on the first clk in ONE.
      level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
      tick_d[i]  = (state_q[i] == WAIT1) && (state_d[i] == ONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      level_q <= '0;
      tick_q  <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.dbg_state = '0;
    for (int i = 0; i < N; i++) begin
      bus.dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign bus.db_level = level_q;
  assign bus.db_tick  = tick_q;
endmodule

// File: tb/tb_btn_debounce_bank.sv
// Directed bench for btn_debounce_bank: an edge-indexed acceptance model feeds an expected queue
// checked every cycle, plus literal latency/pulse-count expectations per scenario.
module tb_btn_debounce_bank;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int S  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  btn_debounce_bank_if #(.N(N)) bus ();

  btn_debounce_bank #(.N(N), .TICK_DIV(D), .SAMPLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- behavioural model ----------------
  // A channel accepts the synchronised level once it has differed from the accepted level
  // continuously from edge run_start onward and S sample ticks fell strictly after run_start.
  logic [2*N-1:0] exp_q[$];
  logic [N-1:0]   m_h1, m_h2;
  int             m_k;
  int             m_run_start [N];
  bit             m_div [N];
  bit             m_acc [N];

  function automatic int ticks_upto(int e);
    return (e + 1) / D;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] lvl, tk;
    bit s;
    if (reset) begin
      m_h1 = '0;
      m_h2 = '0;
      m_k  = 0;
      for (int i = 0; i < N; i++) begin
        m_div[i] = 1'b0;
        m_acc[i] = 1'b0;
        m_run_start[i] = 0;
      end
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      tk = '0;
      for (int i = 0; i < N; i++) begin
        s = m_h2[i];
        if (s == m_acc[i]) begin
          m_div[i] = 1'b0;
        end else if (!m_div[i]) begin
          m_div[i] = 1'b1;
          m_run_start[i] = m_k;
        end else if ((m_k % D == D - 1) &&
                     (ticks_upto(m_k) - ticks_upto(m_run_start[i]) == S)) begin
          m_acc[i] = s;
          m_div[i] = 1'b0;
          tk[i]    = s;
        end
        lvl[i] = m_acc[i];
      end
      m_h2 = m_h1;
      m_h1 = bus.btn_raw;
      m_k++;
      exp_q.push_back({lvl, tk});
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int tick_cnt [N];
  int all_cyc;
  int any_cyc;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(string name, int act, int lo, int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Negedge sample: pop the model's expectation for the last edge and compare both outputs.
  task automatic at_neg();
    logic [2*N-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("db_level", int'(bus.db_level), int'(e[2*N-1:N]));
      check("db_tick",  int'(bus.db_tick),  int'(e[N-1:0]));
    end
    for (int i = 0; i < N; i++) if (bus.db_tick[i]) tick_cnt[i]++;
    if (bus.db_tick == '1) all_cyc++;
    if (bus.db_tick != '0) any_cyc++;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int j = 0; j < n; j++) begin
      at_neg();
      to_pos();
    end
  endtask

  // Drive one channel, then measure edges until db_level[ch] reaches val (bounded).
  task automatic drive_and_measure(int ch, bit val, int budget, output int lat, output int used);
    int p;
    bus.btn_raw[ch] = val;
    p    = ecnt;
    lat  = -1;
    used = 0;
    while (lat < 0 && used < budget) begin
      at_neg();
      if (bus.db_level[ch] == val) lat = ecnt - p;
      to_pos();
      used++;
    end
  endtask

  // ---------------- driver / stimulus ----------------
  initial begin
    int lat, used, t0, t1, t2;
    for (int i = 0; i < N; i++) tick_cnt[i] = 0;
    all_cyc = 0;
    any_cyc = 0;
    bus.btn_raw = '0;
    reset = 1'b1;
    to_pos();
    run(3);
    check("reset_level", int'(bus.db_level), 0);
    check("reset_tick",  int'(bus.db_tick),  0);
    reset = 1'b0;
    run(5);

    // Clean press on channel 0, held 40 clk in total.
    t0 = tick_cnt[0];
    drive_and_measure(0, 1'b1, 30, lat, used);
    check_range("press_latency", lat, 12, 15);
    run(40 - used);
    check("press_tick_count", tick_cnt[0] - t0, 1);
    check("press_level", int'(bus.db_level), 4'b0001);

    // Release glitch: 5 clk low while ONE.
    t0 = tick_cnt[0];
    bus.btn_raw[0] = 1'b0;
    run(5);
    bus.btn_raw[0] = 1'b1;
    run(20);
    check("glitch_level", int'(bus.db_level[0]), 1);
    check("glitch_tick_count", tick_cnt[0] - t0, 0);

    // Clean release, held 20 clk.
    t0 = tick_cnt[0];
    drive_and_measure(0, 1'b0, 20, lat, used);
    check_range("release_latency", lat, 12, 15);
    run(20 - used);
    check("release_tick_count", tick_cnt[0] - t0, 0);
    check("release_level", int'(bus.db_level[0]), 0);

    // Bounce on channel 1: 3 clk high / 3 clk low for 30 clk, then low.
    t1 = tick_cnt[1];
    for (int b = 0; b < 5; b++) begin
      bus.btn_raw[1] = 1'b1;
      run(3);
      bus.btn_raw[1] = 1'b0;
      run(3);
    end
    run(20);
    check("bounce_level", int'(bus.db_level[1]), 0);
    check("bounce_tick_count", tick_cnt[1] - t1, 0);

    // Simultaneous press on all channels.
    t0 = tick_cnt[0]; t1 = tick_cnt[1]; t2 = tick_cnt[2];
    all_cyc = 0;
    any_cyc = 0;
    bus.btn_raw = 4'b1111;
    run(40);
    check("simul_level", int'(bus.db_level), 4'b1111);
    check("simul_tick0", tick_cnt[0] - t0, 1);
    check("simul_tick1", tick_cnt[1] - t1, 1);
    check("simul_tick2", tick_cnt[2] - t2, 1);
    check("simul_all_same_clk", all_cyc, 1);
    check("simul_pulse_cycles", any_cyc, 1);
    bus.btn_raw = '0;
    run(25);
    check("simul_release_level", int'(bus.db_level), 0);

    // Reset while channel 2 sits in WAIT1 with the button held.
    bus.btn_raw[2] = 1'b1;
    run(6);
    check("midop_state_wait1", int'(bus.dbg_state[5:4]), 1);
    reset = 1'b1;
    at_neg();
    check("midop_reset_level", int'(bus.db_level), 0);
    check("midop_reset_tick",  int'(bus.db_tick),  0);
    to_pos();
    run(1);
    reset = 1'b0;
    t2 = tick_cnt[2];
    run(25);
    check("midop_requal_tick", tick_cnt[2] - t2, 1);
    check("midop_level", int'(bus.db_level), 4'b0100);
    bus.btn_raw = '0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
